// File: rtl/lc3_memaccess.sv
// lc3_memaccess: LC3 memory-access stage. Takes the execute-stage opcode,
// effective address and store data on a mem_start pulse and runs the
// data-memory handshake, including the two-access indirect ops LDI and STI.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   mem_start             one-cycle request; IR_Exec/pcout/M_Data valid with it
//   IR_Exec[15:12]        opcode (remaining bits unused)
//   pcout, M_Data         effective address, store data
//   Data_dout             memory read data
//   complete_data         memory completion strobe for the current access
//   Data_addr, Data_din   memory address / write data (hold in IDLE)
//   Data_rd, Data_wr      read / write request
//   mem_state             0=READ 1=IND 2=WRITE 3=IDLE
//   memout                last load result
//   mem_done              one-cycle completion pulse
//   busy                  mem_state != IDLE
//   mem_err               timeout pulse (constant 0 without the macro)
//
// Build option: LC3_MEMACC_TIMEOUT_EN enables the per-access timeout of
// TIMEOUT_CYCLES cycles.
//
// state | meaning
// READ  | load access in flight (direct address or indirect pointer)
// IND   | fetching the pointer word for LDI/STI
// WRITE | store access in flight
// IDLE  | waiting for mem_start

module lc3_memaccess #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_start,
    input  logic [15:0]       IR_Exec,
    input  logic [ADDR_W-1:0] pcout,
    input  logic [ADDR_W-1:0] M_Data,
    input  logic [ADDR_W-1:0] Data_dout,
    input  logic              complete_data,
    output logic [ADDR_W-1:0] Data_addr,
    output logic [ADDR_W-1:0] Data_din,
    output logic              Data_rd,
    output logic              Data_wr,
    output logic [1:0]        mem_state,
    output logic [ADDR_W-1:0] memout,
    output logic              mem_done,
    output logic              busy,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_IND   = 2'd1,
        S_WRITE = 2'd2,
        S_IDLE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    state_t            r_state, w_state_nx;
    logic [3:0]        r_op, w_op_nx;
    logic [ADDR_W-1:0] r_md, w_md_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [ADDR_W-1:0] r_din, w_din_nx;
    logic [ADDR_W-1:0] r_memout, w_memout_nx;
    logic              r_rd, w_rd_nx;
    logic              r_wr, w_wr_nx;
    logic              r_done, w_done_nx;

`ifdef LC3_MEMACC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_err, w_err_nx;
`endif

    // Only the opcode field of IR_Exec matters here.
    logic w_unused;
    assign w_unused = (^IR_Exec[11:0]) ^ (TIMEOUT_CYCLES == 0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_md     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_memout <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_done   <= 1'b0;
`ifdef LC3_MEMACC_TIMEOUT_EN
            r_cnt    <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_op     <= w_op_nx;
            r_md     <= w_md_nx;
            r_addr   <= w_addr_nx;
            r_din    <= w_din_nx;
            r_memout <= w_memout_nx;
            r_rd     <= w_rd_nx;
            r_wr     <= w_wr_nx;
            r_done   <= w_done_nx;
`ifdef LC3_MEMACC_TIMEOUT_EN
            r_cnt    <= w_cnt_nx;
            r_err    <= w_err_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_op_nx     = r_op;
        w_md_nx     = r_md;
        w_addr_nx   = r_addr;
        w_din_nx    = r_din;
        w_memout_nx = r_memout;
        w_rd_nx     = r_rd;
        w_wr_nx     = r_wr;
        w_done_nx   = 1'b0;
`ifdef LC3_MEMACC_TIMEOUT_EN
        w_cnt_nx    = '0;
        w_err_nx    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_rd_nx = 1'b0;
                w_wr_nx = 1'b0;
                if (mem_start) begin
                    case (IR_Exec[15:12])
                        OP_LD, OP_LDR: begin
                            w_state_nx = S_READ;
                            w_rd_nx    = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            w_state_nx = S_IND;
                            w_rd_nx    = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            w_state_nx = S_WRITE;
                            w_wr_nx    = 1'b1;
                            w_din_nx   = M_Data;
                        end
                        default: ;
                    endcase
                    // Unknown opcodes leave every register (and thus the
                    // held Data_addr) untouched.
                    if (w_state_nx != S_IDLE) begin
                        w_op_nx   = IR_Exec[15:12];
                        w_md_nx   = M_Data;
                        w_addr_nx = pcout;
                    end
                end
            end
            S_IND: begin
                if (complete_data) begin
                    // The pointer word becomes the address of the second access.
                    w_addr_nx = Data_dout;
                    if (r_op == OP_STI) begin
                        w_state_nx = S_WRITE;
                        w_rd_nx    = 1'b0;
                        w_wr_nx    = 1'b1;
                        w_din_nx   = r_md;
                    end else begin
                        w_state_nx = S_READ;
                    end
                end
            end
            S_READ: begin
                if (complete_data) begin
                    w_memout_nx = Data_dout;
                    w_done_nx   = 1'b1;
                    w_rd_nx     = 1'b0;
                    w_state_nx  = S_IDLE;
                end
            end
            S_WRITE: begin
                if (complete_data) begin
                    w_done_nx  = 1'b1;
                    w_wr_nx    = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
`ifdef LC3_MEMACC_TIMEOUT_EN
        // Counter is zero on entry to every access state because any state
        // change (or IDLE) leaves w_cnt_nx at its default.
        if (r_state != S_IDLE && !complete_data) begin
            if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                w_state_nx = S_IDLE;
                w_rd_nx    = 1'b0;
                w_wr_nx    = 1'b0;
                w_err_nx   = 1'b1;
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
        end
`endif
    end

    assign Data_addr = r_addr;
    assign Data_din  = r_din;
    assign Data_rd   = r_rd;
    assign Data_wr   = r_wr;
    assign mem_state = r_state;
    assign memout    = r_memout;
    assign mem_done  = r_done;
    assign busy      = (r_state != S_IDLE);
`ifdef LC3_MEMACC_TIMEOUT_EN
    assign mem_err   = r_err;
`else
    assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_memaccess.sv
// Randomized bench for lc3_memaccess. A word-addressed memory model (a
// sparse table over a keyed hash) supplies read data; expected addresses,
// store data, load results and done timing are derived from the LC3
// direct/indirect access rules.

module tb_lc3_memaccess;

    localparam int TO = 4;
`ifdef LC3_MEMACC_TIMEOUT_EN
    localparam int DMAX = 2;
`else
    localparam int DMAX = 6;
`endif
    localparam int D5 = (DMAX < 5) ? DMAX : 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_start;
    logic [15:0] IR_Exec;
    logic [15:0] pcout;
    logic [15:0] M_Data;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic        Data_rd;
    logic        Data_wr;
    logic [1:0]  mem_state;
    logic [15:0] memout;
    logic        mem_done;
    logic        busy;
    logic        mem_err;

    always #5 clock = ~clock;

    lc3_memaccess #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .mem_start(mem_start),
        .IR_Exec(IR_Exec), .pcout(pcout), .M_Data(M_Data),
        .Data_dout(Data_dout), .complete_data(complete_data),
        .Data_addr(Data_addr), .Data_din(Data_din),
        .Data_rd(Data_rd), .Data_wr(Data_wr), .mem_state(mem_state),
        .memout(memout), .mem_done(mem_done), .busy(busy), .mem_err(mem_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] key;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_memout;
    logic [3:0]  op_tab [6] = '{4'h2, 4'h6, 4'hA, 4'h3, 4'h7, 4'hB};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[6:0], a[15:7]} ^ key;
    endfunction

    task automatic quiet_inputs();
        mem_start     = 1'b0;
        complete_data = 1'b0;
        IR_Exec       = 16'($urandom);
        pcout         = 16'($urandom);
        M_Data        = 16'($urandom);
        Data_dout     = 16'($urandom);
    endtask

    // One access state: check it, stall d cycles (optionally poking mem_start),
    // then complete it. Called and returns on a negedge.
    task automatic do_phase(input logic [1:0] st, input logic [15:0] addr, input logic [15:0] md,
                            input int d, input bit extra, input logic [15:0] dout, input bit last);
        check_val("state", mem_state, st);
        check_val("addr", Data_addr, addr);
        check_val("rd", Data_rd, st != 2'd2);
        check_val("wr", Data_wr, st == 2'd2);
        check_val("busy", busy, 1);
        check_val("done_early", mem_done, 0);
        check_val("err", mem_err, 0);
        if (st == 2'd2) check_val("din", Data_din, md);
        for (int i = 0; i < d; i++) begin
            quiet_inputs();
            mem_start = extra && ($urandom % 2 == 1);
            @(negedge clock);
            mem_start = 1'b0;
            check_val("stall_state", mem_state, st);
            check_val("stall_addr", Data_addr, addr);
            if (st == 2'd2) check_val("stall_din", Data_din, md);
        end
        complete_data = 1'b1;
        Data_dout     = dout;
        if (last && ($urandom % 2 == 1)) begin
            mem_start = 1'b1;
            IR_Exec   = 16'h2000 | 16'($urandom_range(0, 4095));
        end
        @(negedge clock);
        quiet_inputs();
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] md,
                          input int dmin, input int dmax, input bit extra);
        bit          is_load = (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
        bit          is_ind  = (op == 4'hA) || (op == 4'hB);
        bit          valid   = is_load || (op == 4'h3) || (op == 4'h7) || (op == 4'hB);
        logic [15:0] ea      = is_ind ? mem_rd(pc) : pc;
        mem_start = 1'b1;
        IR_Exec   = {op, 12'($urandom)};
        pcout     = pc;
        M_Data    = md;
        @(negedge clock);
        quiet_inputs();
        if (!valid) begin
            check_val("bad_op_state", mem_state, 2'd3);
            check_val("bad_op_rdwr", {Data_rd, Data_wr}, 0);
            @(negedge clock);
            check_val("bad_op_done", mem_done, 0);
            return;
        end
        if (is_ind)
            do_phase(2'd1, pc, md, $urandom_range(dmin, dmax), extra, mem_rd(pc), 1'b0);
        do_phase(is_load ? 2'd0 : 2'd2, ea, md, $urandom_range(dmin, dmax), extra,
                 is_load ? mem_rd(ea) : 16'($urandom), 1'b1);
        if (is_load) exp_memout = mem_rd(ea);
        check_val("done", mem_done, 1);
        check_val("end_state", mem_state, 2'd3);
        check_val("end_busy", busy, 0);
        check_val("memout", memout, exp_memout);
        check_val("end_rdwr", {Data_rd, Data_wr}, 0);
        @(negedge clock);
        check_val("done_once", mem_done, 0);
        check_val("start_at_done_ignored", mem_state, 2'd3);
    endtask

    initial begin
        reset = 1'b0;
        quiet_inputs();
        key        = 16'($urandom);
        exp_memout = 16'h0;
        repeat (2) @(negedge clock);
        check_val("rst_state", mem_state, 2'd3);
        check_val("rst_busy", busy, 0);
        check_val("rst_addr", Data_addr, 0);
        check_val("rst_din", Data_din, 0);
        check_val("rst_rdwr", {Data_rd, Data_wr}, 0);
        check_val("rst_memout", memout, 0);
        check_val("rst_flags", {mem_done, mem_err}, 0);
        reset = 1'b1;
        @(negedge clock);

        mem[16'h3010] = 16'hBEEF;
        run_op(4'h2, 16'h3010, 16'h0, 0, 0, 1'b0);
        run_op(4'h7, 16'h4000, 16'h1234, 0, 2, 1'b0);
        mem[16'h3000] = 16'h5000;
        mem[16'h5000] = 16'hCAFE;
        run_op(4'hA, 16'h3000, 16'h0, 0, 0, 1'b0);
        mem[16'h3100] = 16'h6000;
        run_op(4'hB, 16'h3100, 16'hABCD, D5, D5, 1'b1);
        run_op(4'h1, 16'h2222, 16'h3333, 0, 0, 1'b0);

        // Reset in the middle of an LDI pointer fetch, then a stale completion.
        mem_start = 1'b1;
        IR_Exec   = 16'hA000;
        pcout     = 16'h3000;
        @(negedge clock);
        quiet_inputs();
        check_val("ldi_ind", mem_state, 2'd1);
        #2 reset = 1'b0;
        #1;
        check_val("abort_state", mem_state, 2'd3);
        check_val("abort_addr", Data_addr, 0);
        check_val("abort_rdwr", {Data_rd, Data_wr}, 0);
        check_val("abort_memout", memout, 0);
        check_val("abort_busy", busy, 0);
        @(negedge clock);
        reset         = 1'b1;
        complete_data = 1'b1;
        Data_dout     = 16'h1111;
        @(negedge clock);
        complete_data = 1'b0;
        check_val("stale_state", mem_state, 2'd3);
        check_val("stale_done", mem_done, 0);
        check_val("stale_memout", memout, 0);
        check_val("stale_rd", Data_rd, 0);
        exp_memout = 16'h0;
        run_op(4'h6, 16'h3010, 16'h0, 0, 1, 1'b0);

`ifdef LC3_MEMACC_TIMEOUT_EN
        mem_start = 1'b1;
        IR_Exec   = 16'h2000;
        pcout     = 16'h7777;
        @(negedge clock);
        quiet_inputs();
        for (int i = 0; i < TO - 1; i++) begin
            check_val("to_wait_state", mem_state, 2'd0);
            check_val("to_wait_err", mem_err, 0);
            @(negedge clock);
        end
        check_val("to_wait_state", mem_state, 2'd0);
        @(negedge clock);
        check_val("to_err", mem_err, 1);
        check_val("to_state", mem_state, 2'd3);
        check_val("to_rd", Data_rd, 0);
        check_val("to_done", mem_done, 0);
        check_val("to_memout", memout, exp_memout);
        @(negedge clock);
        check_val("to_err_pulse", mem_err, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            op = ($urandom % 8 == 0) ? 4'($urandom) : op_tab[$urandom % 6];
            run_op(op, 16'($urandom), 16'($urandom), 0, DMAX, ($urandom % 2 == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
